// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host transmitter: state encoding, default
// timing, and a helper that sizes the shared inhibit/timeout counter.
package ps2_pkg;

    localparam int INHIBIT_CYCLES_DEF = 2500;
    localparam int TIMEOUT_CYCLES_DEF = 375000;
    localparam int MIN_CNT_W          = 19;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_INHIBIT   = 4'd1;
    localparam logic [3:0] ST_START     = 4'd2;
    localparam logic [3:0] ST_DATA      = 4'd3;
    localparam logic [3:0] ST_PARITY    = 4'd4;
    localparam logic [3:0] ST_STOP      = 4'd5;
    localparam logic [3:0] ST_ACK       = 4'd6;
    localparam logic [3:0] ST_WAIT_IDLE = 4'd7;

    // Counter width large enough for either phase, never below 19 bits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w > MIN_CNT_W) ? w : MIN_CNT_W;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake plus raw PS/2 line levels and open-drain enables.
// The master side is the environment: it issues commands and owns the pads.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line, plus a falling-edge strobe
// taken from the synchronized level.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: idle PS/2 lines sit high; resetting to 1 avoids a false edge on release.
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make these three flops a true shift chain.
            meta_q <= raw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, sends start, 8 data
// bits LSB first, odd parity and stop, then samples the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic          clk,
    input logic          reset_n,
    ps2_host_tx_if.slave bus
);

    localparam int              CNT_W       = cnt_width(INHIBIT_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] INH_LAST    = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_PRELAST = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic clk_s, clk_fall;
    logic data_s, data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (bus.ps2_clk_in),
        .level_o (clk_s),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_i   (bus.ps2_data_in),
        .level_o (data_s),
        .fall_o  (data_fall_unused)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                if (bus.tx_valid) begin
                    shift_d   = bus.tx_data;
                    parity_d  = ~^bus.tx_data;
                    cnt_d     = '0;
                    data_oe_d = (INHIBIT_CYCLES == 1);
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Data is pulled low in the final inhibit cycle to present the start bit.
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_START;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    data_oe_d = (cnt_q == INH_PRELAST);
                end
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_ACK: begin
                if (cnt_q == TO_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (clk_fall) begin
                        case (state_q)
                            ST_START: begin
                                data_oe_d = ~shift_q[0];
                                shift_d   = {1'b0, shift_q[7:1]};
                                bit_cnt_d = '0;
                                state_d   = ST_DATA;
                            end
                            ST_DATA: begin
                                if (bit_cnt_q == 4'd7) begin
                                    data_oe_d = ~parity_q;
                                    state_d   = ST_PARITY;
                                end else begin
                                    data_oe_d = ~shift_q[0];
                                    shift_d   = {1'b0, shift_q[7:1]};
                                    bit_cnt_d = bit_cnt_q + 4'd1;
                                end
                            end
                            ST_PARITY: begin
                                data_oe_d = 1'b0;
                                state_d   = ST_STOP;
                            end
                            ST_STOP: state_d = ST_ACK;
                            ST_ACK: begin
                                done_d    = ~data_s;
                                error_d   = data_s;
                                cnt_d     = '0;
                                bit_cnt_d = '0;
                                state_d   = ST_WAIT_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) state_d = ST_IDLE;
            end
            default: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        clk_oe_d = (state_d == ST_INHIBIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.tx_ready    = (state_q == ST_IDLE);
    assign bus.tx_busy     = (state_q != ST_IDLE);
    assign bus.tx_done     = done_q;
    assign bus.tx_error    = error_q;
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device on open-drain
// lines clocks frames, captures the line bits and optionally ACKs.
module tb_ps2_host_tx;

    localparam int TB_INH = 16;
    localparam int TB_TO  = 1000;
    localparam int HALF   = 20;

    logic clk = 1'b0;
    logic reset_n;
    logic dev_clk_rel;
    logic dev_data_rel;

    int n_checks    = 0;
    int n_fail      = 0;
    int done_total  = 0;
    int error_total = 0;
    bit both_seen   = 1'b0;

    int   inh_len;
    logic inh_last_doe;
    logic inh_prev_doe;
    logic start_line;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (TB_INH),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of the device and the host enables.
    assign bus.ps2_clk_in  = dev_clk_rel  & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = dev_data_rel & ~bus.ps2_data_oe;

    always @(negedge clk) begin
        if (bus.tx_done === 1'b1)  done_total  <= done_total + 1;
        if (bus.tx_error === 1'b1) error_total <= error_total + 1;
        if (bus.tx_done === 1'b1 && bus.tx_error === 1'b1) both_seen <= 1'b1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (bus.tx_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (bus.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: tx_ready=%b, required 1 within 500 cycles", tag, bus.tx_ready);
        end
    endtask

    // Device: observe inhibit, then clock 12 pulses; frame = data[7:0], parity, stop.
    task automatic device_xfer(input logic ack_low, input int abort_falls,
                               input bit glitch_en, input logic [7:0] glitch_data,
                               output logic [9:0] frame);
        int guard = 0;
        frame        = '0;
        inh_len      = 0;
        inh_last_doe = 1'b0;
        inh_prev_doe = 1'b0;
        while (bus.ps2_clk_oe !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        while (bus.ps2_clk_oe === 1'b1 && inh_len < TB_INH + 100) begin
            inh_prev_doe = inh_last_doe;
            inh_last_doe = bus.ps2_data_oe;
            inh_len++;
            @(negedge clk);
        end
        if (inh_len == 0 || bus.ps2_clk_oe === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL device_inhibit: inhibit length %0d, required %0d", inh_len, TB_INH);
            return;
        end
        start_line = bus.ps2_data_in;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            dev_clk_rel = 1'b0;
            if (glitch_en && k == 3) begin
                bus.tx_data  = glitch_data;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (k == abort_falls) return;
            if (k <= 10) frame[k-1] = bus.ps2_data_in;
            dev_clk_rel = 1'b1;
            if (k == 11) dev_data_rel = ~ack_low;
            if (k == 12) dev_data_rel = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        dev_clk_rel  = 1'b1;
        dev_data_rel = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.tx_ready, bus.tx_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_ready_busy: got %b, expected 10", {bus.tx_ready, bus.tx_busy});
        end
        n_checks++;
        if ({bus.tx_done, bus.tx_error} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b, expected 00", {bus.tx_done, bus.tx_error});
        end
        n_checks++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_oe: got %b, expected 00", {bus.ps2_clk_oe, bus.ps2_data_oe});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_send_ed();
        logic [9:0] frame;
        int d0 = done_total;
        int e0 = error_total;
        send_byte(8'hED);
        device_xfer(1'b1, 0, 1'b0, 8'h00, frame);
        wait_ready("ed_ready");
        repeat (2) @(negedge clk);
        n_checks++;
        if (inh_len != TB_INH) begin
            n_fail++;
            $display("FAIL ed_inhibit_len: got %0d, expected %0d", inh_len, TB_INH);
        end
        n_checks++;
        if ({inh_prev_doe, inh_last_doe} !== 2'b01) begin
            n_fail++;
            $display("FAIL ed_inhibit_data_oe: got %b, expected 01", {inh_prev_doe, inh_last_doe});
        end
        n_checks++;
        if (start_line !== 1'b0) begin
            n_fail++;
            $display("FAIL ed_start_bit: got %b, expected 0", start_line);
        end
        n_checks++;
        if (frame !== 10'h3ED) begin
            n_fail++;
            $display("FAIL ed_frame: got %h, expected 3ed", frame);
        end
        n_checks++;
        if ((done_total - d0) != 1 || (error_total - e0) != 0) begin
            n_fail++;
            $display("FAIL ed_pulses: done %0d error %0d, expected 1 and 0",
                     done_total - d0, error_total - e0);
        end
    endtask

    task automatic test_parity();
        logic [7:0] bytes [3] = '{8'h07, 8'h00, 8'hFF};
        logic [9:0] exp   [3] = '{10'h207, 10'h300, 10'h3FF};
        logic [9:0] frame;
        for (int i = 0; i < 3; i++) begin
            int d0 = done_total;
            send_byte(bytes[i]);
            device_xfer(1'b1, 0, 1'b0, 8'h00, frame);
            wait_ready("parity_ready");
            repeat (2) @(negedge clk);
            n_checks++;
            if (frame !== exp[i]) begin
                n_fail++;
                $display("FAIL parity_frame_%h: got %h, expected %h", bytes[i], frame, exp[i]);
            end
            n_checks++;
            if ((done_total - d0) != 1) begin
                n_fail++;
                $display("FAIL parity_done_%h: got %0d, expected 1", bytes[i], done_total - d0);
            end
        end
    endtask

    task automatic test_timeout();
        int guard = 0;
        int k = 0;
        int d0 = done_total;
        int e0 = error_total;
        send_byte(8'hA5);
        while (bus.ps2_clk_oe === 1'b1 && guard < TB_INH + 50) begin
            @(negedge clk);
            guard++;
        end
        while (bus.tx_error !== 1'b1 && k < 2 * TB_TO) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != TB_TO) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", k, TB_TO);
        end
        n_checks++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_oe: got %b, expected 00", {bus.ps2_clk_oe, bus.ps2_data_oe});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.tx_ready, bus.tx_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_ready_next: got %b, expected 10", {bus.tx_ready, bus.tx_error});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ((done_total - d0) != 0 || (error_total - e0) != 1) begin
            n_fail++;
            $display("FAIL timeout_pulses: done %0d error %0d, expected 0 and 1",
                     done_total - d0, error_total - e0);
        end
    endtask

    task automatic test_no_ack();
        logic [9:0] frame;
        int d0 = done_total;
        int e0 = error_total;
        send_byte(8'h5A);
        device_xfer(1'b0, 0, 1'b0, 8'h00, frame);
        wait_ready("noack_ready");
        repeat (2) @(negedge clk);
        n_checks++;
        if (frame !== 10'h35A) begin
            n_fail++;
            $display("FAIL noack_frame: got %h, expected 35a", frame);
        end
        n_checks++;
        if ((done_total - d0) != 0 || (error_total - e0) != 1) begin
            n_fail++;
            $display("FAIL noack_pulses: done %0d error %0d, expected 0 and 1",
                     done_total - d0, error_total - e0);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] frame;
        int d0;
        int e0;
        send_byte(8'h00);
        device_xfer(1'b1, 5, 1'b0, 8'h00, frame);
        n_checks++;
        if ({bus.tx_busy, bus.ps2_data_oe} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_bit4_driven: got %b, expected 11", {bus.tx_busy, bus.ps2_data_oe});
        end
        d0 = done_total;
        e0 = error_total;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_ready, bus.tx_busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL midreset_release: got %b, expected 0010",
                     {bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_ready, bus.tx_busy});
        end
        dev_clk_rel = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if ((done_total - d0) != 0 || (error_total - e0) != 0) begin
            n_fail++;
            $display("FAIL midreset_pulses: done %0d error %0d, expected 0 and 0",
                     done_total - d0, error_total - e0);
        end
        d0 = done_total;
        send_byte(8'hF4);
        device_xfer(1'b1, 0, 1'b0, 8'h00, frame);
        wait_ready("f4_ready");
        repeat (2) @(negedge clk);
        n_checks++;
        if (frame !== 10'h2F4) begin
            n_fail++;
            $display("FAIL f4_frame: got %h, expected 2f4", frame);
        end
        n_checks++;
        if ((done_total - d0) != 1) begin
            n_fail++;
            $display("FAIL f4_done: got %0d, expected 1", done_total - d0);
        end
    endtask

    task automatic test_ignore_valid();
        logic [9:0] frame;
        int d0 = done_total;
        send_byte(8'h3C);
        device_xfer(1'b1, 0, 1'b1, 8'hA5, frame);
        wait_ready("ignore_ready");
        repeat (30) @(negedge clk);
        n_checks++;
        if (frame !== 10'h33C) begin
            n_fail++;
            $display("FAIL ignore_frame: got %h, expected 33c", frame);
        end
        n_checks++;
        if ((done_total - d0) != 1 || {bus.tx_ready, bus.ps2_clk_oe} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignore_after: done %0d ready/clk_oe %b, expected 1 and 10",
                     done_total - d0, {bus.tx_ready, bus.ps2_clk_oe});
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_timeout();
        test_no_ack();
        test_reset_mid();
        test_ignore_valid();
        n_checks++;
        if (both_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL done_error_overlap: got %b, expected 0", both_seen);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2500; clock-low inhibit length in clk cycles (100 us at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 375000; maximum clk cycles from clock release to ACK sampled (15 ms at 25 MHz).
REQ-003 SHALL have clk  input  1  single clock for all logic.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have tx_data  input  8  command byte to send to the keyboard (e.g. 0xED LED command).
REQ-006 SHALL have tx_valid  input  1  request; accepted only in a cycle where tx_ready=1.
REQ-007 SHALL have tx_ready  output  1  high only in IDLE.
REQ-008 SHALL have tx_busy  output  1  high in every state except IDLE; the scancode receiver ignores bytes while high.
REQ-009 SHALL have tx_done  output  1  one-cycle pulse when the transfer ends with ACK received.
REQ-010 SHALL have tx_error  output  1  one-cycle pulse when the transfer ends on timeout or missing ACK.
REQ-011 SHALL have ps2_clk_in, ps2_data_in  input  1 each  raw, asynchronous line levels.
REQ-012 SHALL have ps2_clk_oe, ps2_data_oe  output  1 each  1 = pull the open-drain line low, 0 = release it.

Function
REQ-013 SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers before any use.
REQ-014 SHALL detect a PS/2 clock falling edge as synchronized clock previous=1, current=0; one pulse per edge.
REQ-015 SHALL latch tx_data and compute odd parity (parity = ~^tx_data) when tx_valid && tx_ready.
REQ-016 SHALL use states IDLE -> INHIBIT -> START -> DATA -> PARITY -> STOP -> ACK -> WAIT_IDLE -> IDLE.
REQ-017 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; in the last cycle ps2_data_oe=1 (start bit 0).
REQ-018 START: ps2_clk_oe=0 and ps2_data_oe=1; the timeout counter starts; advances to DATA on the first falling edge.
REQ-019 DATA: on each falling edge, drive bit n LSB first (ps2_data_oe = ~bit); advance to PARITY after bit 7.
REQ-020 PARITY: drive the parity bit on the next falling edge; the following edge releases data (stop=1) and enters STOP.
REQ-021 STOP: ps2_data_oe=0; on the next falling edge enter ACK.
REQ-022 ACK: sample synchronized data on the first falling edge; 0 -> tx_done pulse, 1 -> tx_error pulse; both go to WAIT_IDLE.
REQ-023 WAIT_IDLE: remain until both synchronized lines are 1, then go to IDLE.
REQ-024 SHALL count to TIMEOUT_CYCLES in START..ACK; on expiry release both lines, pulse tx_error and go to IDLE, no ACK sampling.
REQ-025 tx_done and tx_error SHALL never be high in the same cycle, and only one SHALL pulse per transfer.
REQ-026 SHALL ignore tx_valid while tx_busy=1; a tx_valid in the cycle returning to IDLE is accepted on the next cycle only.
REQ-027 SHALL keep a 4-bit bit counter (0..7) and a counter of at least 19 bits; neither counter SHALL wrap.

Reset
REQ-028 On reset_n=0, immediately: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_busy=0, tx_done=0, tx_error=0, counters 0, synchronizers 1.
REQ-029 Reset mid-transfer SHALL release both lines at once with no done/error pulse.

Structure
REQ-030 State encoding and the default INHIBIT/TIMEOUT constants SHALL live in shared package ps2_pkg.
REQ-031 The synchronizer plus falling-edge detector SHALL be sub-module ps2_sync_edge, instanced once for clk and once for data (edge output used only for clk).
REQ-032 SHALL contain no tristate; the top level builds the open-drain pads from the *_oe outputs.

Verification
REQ-033 Send 0xED; device model clocks at 12.5 kHz and ACKs -> line bits 1,0,1,1,0,1,1,1, parity 1, stop 1; exactly one tx_done.
REQ-034 Send 0x07 -> parity bit 0; send 0x00 and 0xFF -> parity bit 1.
REQ-035 Device never clocks -> tx_error exactly TIMEOUT_CYCLES after clock release, both oe=0, tx_ready=1 next cycle.
REQ-036 Device clocks but holds data high at ACK -> tx_error pulse; no tx_done.
REQ-037 Assert reset_n=0 during bit 4 -> both oe=0 in the same cycle; no pulses; a new 0xF4 send then completes with tx_done.
REQ-038 Pulse tx_valid during DATA with a different byte -> ignored; original byte is sent unchanged.
